// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, MEM-stage FSM encoding,
// watchdog default and a small opcode helper.
package pipe_pkg;

    localparam int TIMEOUT_DEFAULT = 16;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_watchdog.sv
// Counts ACCESS cycles; expired marks the last cycle the request
// may still be acknowledged before it is abandoned.
module mem_stage_watchdog
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU pass-through, aligned LW/SW against a
// handshaked data memory, misalignment and timeout error reporting.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    mem_state_e state, state_nx;

    logic        accept;
    logic        aligned;
    logic        mem_op;
    logic        expired;
    logic [4:0]  rd_q, rd_q_nx;

    logic        mem_req_nx, mem_we_nx;
    logic [31:0] mem_addr_nx, mem_wdata_nx;
    logic        wb_valid_nx, wb_we_nx, err_nx;
    logic [4:0]  wb_rd_nx;
    logic [31:0] wb_data_nx;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign aligned  = (alu_result[1:0] == 2'b00);
    assign mem_op   = is_mem_op(opcode);

    mem_stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .en      (state == ST_ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept && mem_op && aligned) begin
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || expired) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; an ack beats a same-cycle timeout.
    always_comb begin
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        rd_q_nx      = rd_q;
        wb_valid_nx  = 1'b0;
        wb_we_nx     = 1'b0;
        err_nx       = 1'b0;
        wb_rd_nx     = wb_rd;
        wb_data_nx   = wb_data;

        if (state == ST_IDLE) begin
            if (accept) begin
                unique case (1'b1)
                    (opcode == OP_ADD): begin
                        wb_valid_nx = 1'b1;
                        wb_we_nx    = (rd != 5'd0);
                        wb_rd_nx    = rd;
                        wb_data_nx  = alu_result;
                    end
                    (opcode == OP_BEQ): begin
                        wb_valid_nx = 1'b1;
                        wb_rd_nx    = rd;
                        wb_data_nx  = alu_result;
                    end
                    (mem_op && !aligned): begin
                        wb_valid_nx = 1'b1;
                        err_nx      = 1'b1;
                        wb_rd_nx    = rd;
                        wb_data_nx  = alu_result;
                    end
                    (mem_op && aligned): begin
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = (opcode == OP_SW);
                        mem_addr_nx  = alu_result;
                        mem_wdata_nx = store_data;
                        rd_q_nx      = rd;
                    end
                    default: ;
                endcase
            end
        end else begin
            if (mem_ack) begin
                mem_req_nx  = 1'b0;
                mem_we_nx   = 1'b0;
                wb_valid_nx = 1'b1;
                wb_rd_nx    = rd_q;
                wb_we_nx    = !mem_we && (rd_q != 5'd0);
                wb_data_nx  = mem_we ? mem_addr : mem_rdata;
            end else if (expired) begin
                mem_req_nx  = 1'b0;
                mem_we_nx   = 1'b0;
                wb_valid_nx = 1'b1;
                err_nx      = 1'b1;
                wb_rd_nx    = rd_q;
                wb_data_nx  = mem_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_q      <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            err       <= 1'b0;
        end else begin
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            rd_q      <= rd_q_nx;
            wb_valid  <= wb_valid_nx;
            wb_we     <= wb_we_nx;
            wb_rd     <= wb_rd_nx;
            wb_data   <= wb_data_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: timeline model of expected
// write-backs, checked by an independent negedge monitor.
module tb_mem_stage;
    import pipe_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [5:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid, wb_we, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .store_data (store_data),
        .opcode     (opcode),
        .rd         (rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          we;
        bit          err;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          crd;
        bit          cdata;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int passed = 0;
    logic [5:0] unk_ops [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%h required=%h (cycle %0d)",
                      name, act, req, cyc);
    endtask

    // Monitor: every write-back must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (wb_valid) begin
                if (q.size() == 0) begin
                    chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                    chk("wb_err", {31'd0, err}, {31'd0, e.err});
                    if (e.crd) chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    if (e.cdata) chk("wb_data", wb_data, e.data);
                end
            end else if (err) begin
                chk("err_without_wb", {31'd0, err}, 32'd0);
            end
        end
    end

    // Present one instruction at a negedge; k = ack wait cycles, <0 = never.
    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r,
                         input int k, input logic [31:0] rdv);
        bit   is_mem, algn, tmo;
        int   n, waits;
        exp_t e;
        is_mem = (op == OP_LW) || (op == OP_SW);
        algn   = (a[1:0] == 2'b00);
        tmo    = (k < 0) || (k >= TO);
        in_valid   = 1'b1;
        opcode     = op;
        alu_result = a;
        store_data = d;
        rd         = r;
        chk("in_ready", {31'd0, in_ready}, 32'd1);
        n = cyc + 1;
        e = '{cyc: n, we: 1'b0, err: 1'b0, rd: r, data: a,
              crd: 1'b1, cdata: 1'b1};
        if (op == OP_ADD) begin
            e.we = (r != 5'd0);
            q.push_back(e);
        end else if (op == OP_BEQ) begin
            e.crd = 1'b0;
            q.push_back(e);
        end else if (is_mem && !algn) begin
            e.err = 1'b1; e.crd = 1'b0; e.cdata = 1'b0;
            q.push_back(e);
        end else if (is_mem && tmo) begin
            e.cyc = n + TO;
            e.err = 1'b1; e.crd = 1'b0; e.cdata = 1'b0;
            q.push_back(e);
        end else if (op == OP_LW) begin
            e.cyc = n + k + 1;
            e.we = (r != 5'd0);
            e.data = rdv;
            q.push_back(e);
        end else if (op == OP_SW) begin
            e.cyc = n + k + 1;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        opcode     = 6'($urandom);
        alu_result = $urandom;
        store_data = $urandom;
        rd         = 5'($urandom);
        if (is_mem && algn) begin
            waits = tmo ? TO : k + 1;
            for (int j = 0; j < waits; j++) begin
                chk("mem_req", {31'd0, mem_req}, 32'd1);
                chk("mem_addr", mem_addr, a);
                chk("mem_we", {31'd0, mem_we}, {31'd0, op == OP_SW});
                if (op == OP_SW) chk("mem_wdata", mem_wdata, d);
                chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                mem_ack   = !tmo && (j == k);
                mem_rdata = mem_ack ? rdv : $urandom;
                in_valid  = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
        chk("mem_req_idle", {31'd0, mem_req}, 32'd0);
        chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        logic [4:0]  r;
        int          k, sel;

        unk_ops[0] = 6'h08; unk_ops[1] = 6'h0d; unk_ops[2] = 6'h0f;
        unk_ops[3] = 6'h20; unk_ops[4] = 6'h2a; unk_ops[5] = 6'h3f;

        #2;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(OP_ADD, 32'h0000_0005, 32'h0, 5'd3, 0, 32'h0);
        issue(OP_ADD, 32'h0000_0009, 32'h0, 5'd0, 0, 32'h0);
        issue(OP_LW, 32'h0000_0100, 32'h0, 5'd5, 3, 32'hDEAD_BEEF);
        issue(OP_SW, 32'h0000_0200, 32'h1234, 5'd7, 0, 32'h0);
        issue(OP_LW, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h0);
        issue(OP_SW, 32'h0000_0203, 32'h55, 5'd4, 0, 32'h0);
        issue(OP_LW, 32'h0000_0104, 32'h0, 5'd6, -1, 32'h0);
        issue(OP_LW, 32'h0000_0108, 32'h0, 5'd8, TO - 1, 32'hCAFE_0001);
        issue(OP_BEQ, 32'h0000_00AA, 32'h0, 5'd9, 0, 32'h0);
        issue(6'h08, 32'h0000_0011, 32'h0, 5'd1, 0, 32'h0);
        issue(OP_LW, 32'h0000_010C, 32'h0, 5'd0, 1, 32'h1111_2222);

        // Reset while a load is waiting on memory.
        in_valid = 1'b1; opcode = OP_LW; alu_result = 32'h300; rd = 5'd2;
        mem_ack = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        issue(OP_ADD, 32'h0000_0042, 32'h0, 5'd12, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            k = $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) k = -1;
            else if ($urandom_range(0, 19) == 0) k = TO - 1;
            if (sel < 3) op = OP_ADD;
            else if (sel == 3) op = OP_BEQ;
            else if (sel == 4) op = unk_ops[$urandom_range(0, 5)];
            else if (sel < 7) op = OP_LW;
            else op = OP_SW;
            issue(op, a, $urandom, r, k, $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles allowed without mem_ack before abort.
REQ-002 SHALL provide: clk  in  1  single clock; all state is on its rising edge.
REQ-003 SHALL provide: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL provide: in_valid  in  1  EX result present this cycle.
REQ-005 SHALL provide: in_ready  out  1  stage can accept this cycle; the pipeline stalls upstream when low.
REQ-006 SHALL provide: alu_result  in  32  ALU result or byte address from EX.
REQ-007 SHALL provide: store_data  in  32  rt value for SW.
REQ-008 SHALL provide: opcode  in  6  instruction opcode from EX.
REQ-009 SHALL provide: rd  in  5  destination register from EX.
REQ-010 SHALL provide: mem_req, mem_we  out  1 each  data-memory request and write strobe.
REQ-011 SHALL provide: mem_addr, mem_wdata  out  32 each  word address and store data.
REQ-012 SHALL provide: mem_ack  in  1  memory completes the held request this cycle.
REQ-013 SHALL provide: mem_rdata  in  32  load data, valid when mem_ack=1.
REQ-014 SHALL provide: wb_valid  out  1  one-cycle write-back pulse.
REQ-015 SHALL provide: wb_we  out  1  register write enable.
REQ-016 SHALL provide: wb_rd  out  5  write-back register index.
REQ-017 SHALL provide: wb_data  out  32  write-back value.
REQ-018 SHALL provide: err  out  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-019 SHALL implement a 2-state FSM, IDLE and ACCESS; in_ready SHALL equal (state==IDLE).
REQ-020 Acceptance SHALL be defined as in_valid & in_ready at a rising edge.
REQ-021 Accepted ADD (000000) SHALL give, next cycle: wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_we=(rd!=0); state stays IDLE.
REQ-022 Accepted BEQ (000100) SHALL give, next cycle: wb_valid=1, wb_we=0, wb_data=alu_result; state stays IDLE.
REQ-023 Accepted unknown opcode SHALL be a bubble: no wb_valid, no err.
REQ-024 Accepted LW (100011) or SW (101011) with alu_result[1:0]!=0 SHALL not touch memory; the next cycle SHALL give wb_valid=1, wb_we=0, err=1.
REQ-025 Accepted aligned LW/SW SHALL latch address, data, opcode and rd, then enter ACCESS.
REQ-026 In ACCESS, mem_req=1, mem_addr, mem_wdata and mem_we=(SW) SHALL be held stable until mem_ack.
REQ-027 On mem_ack in ACCESS, the FSM SHALL return to IDLE; next cycle wb_valid=1 and wb_rd=latched rd.
REQ-028 For LW on completion, wb_data SHALL be mem_rdata sampled at ack and wb_we=(rd!=0).
REQ-029 For SW on completion, wb_we=0 and wb_data=address.
REQ-030 Memory-op latency SHALL be 2+k cycles from acceptance to wb_valid, where k = ACCESS cycles before ack (k>=0, ack possible in first ACCESS cycle).
REQ-031 A wait counter SHALL count ACCESS cycles; when it reaches TIMEOUT without ack, the FSM SHALL return to IDLE, drop mem_req, and next cycle pulse wb_valid=1, wb_we=0, err=1.
REQ-032 mem_ack in the same cycle as timeout SHALL be treated as a normal completion.
REQ-033 mem_ack while IDLE SHALL be ignored.
REQ-034 A new instruction SHALL be acceptable in the same cycle that the previous wb_valid is high.
REQ-035 The wb_*, err and mem_* outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-036 reset low SHALL immediately force state=IDLE, counter=0, all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, wb_*, err), and in_ready=1 after release.
REQ-037 Reset during ACCESS SHALL abandon the request with no wb_valid and no err.

Structure
REQ-038 Opcode constants (ADD, LW, SW, BEQ), the FSM state encoding and the TIMEOUT default SHALL live in shared package pipe_pkg.
REQ-039 The timeout counter SHALL be sub-module mem_stage_watchdog (inputs: clear, count enable; output: expired).

Verification
REQ-040 ADD, alu_result=0x0000_0005, rd=3 -> next cycle wb_valid=1, wb_we=1, wb_rd=3, wb_data=5; ADD with rd=0 -> wb_we=0.
REQ-041 LW, addr 0x100, ack after 3 wait cycles, rdata 0xDEAD_BEEF -> mem_req held 4 cycles, in_ready=0 throughout, wb_data=0xDEADBEEF at acceptance+5.
REQ-042 SW, addr 0x200, data 0x1234, zero-wait ack -> mem_we=1 for one cycle, wb_valid at acceptance+2 with wb_we=0.
REQ-043 LW, addr 0x102 -> mem_req never asserted; next cycle err=1, wb_we=0.
REQ-044 LW, ack never given, TIMEOUT=16 -> mem_req drops after 16 ACCESS cycles; err=1 with wb_valid; in_ready=1.
REQ-045 reset asserted mid-ACCESS -> mem_req=0 immediately; no wb_valid; an ADD after release completes normally.
